// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the FP writeback stage: opcodes, IEEE-754 single
// field widths, the value class enum and the bit positions of the NZCV and
// sticky-flag vectors.
// ---------------------------------------------------------------------------
package fp_pkg;

  localparam logic [1:0] FP_OP_ADD = 2'b00;
  localparam logic [1:0] FP_OP_MUL = 2'b01;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  typedef enum logic [2:0] {
    FPC_ZERO,
    FPC_DENORM,
    FPC_NORMAL,
    FPC_INF,
    FPC_NAN
  } fp_class_e;

  // Sticky flag vector {IOC,OFC,UFC,ZRC}
  localparam int FLAG_IOC = 3;
  localparam int FLAG_OFC = 2;
  localparam int FLAG_UFC = 1;
  localparam int FLAG_ZRC = 0;

  // Condition flag vector {N,Z,C,V}
  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  // Exception bits contributed by a single pushed result.
  function automatic logic [3:0] sticky_bits(fp_class_e cls, logic op_invalid);
    logic [3:0] bits;
    bits           = '0;
    bits[FLAG_IOC] = (cls == FPC_NAN) | op_invalid;
    bits[FLAG_OFC] = (cls == FPC_INF);
    bits[FLAG_UFC] = (cls == FPC_DENORM);
    bits[FLAG_ZRC] = (cls == FPC_ZERO);
    return bits;
  endfunction

endpackage

// File: rtl/fp_writeback_stage_if.sv
// ---------------------------------------------------------------------------
// fp_writeback_stage_if
// Handshake bundle between the FP add/mul unit, the writeback stage and the
// register-file writeback port.
//   in_*        : result from the FP unit (valid/ready)
//   out_*       : buffered result towards writeback (valid/ready)
// master modport = the environment (producer + consumer), slave = the stage.
// ---------------------------------------------------------------------------
interface fp_writeback_stage_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [1:0]        in_op;
  logic [RD_W-1:0]   in_rd;
  logic              in_setflags;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [RD_W-1:0]   out_rd;
  logic              out_setflags;
  logic [3:0]        out_nzcv;

  modport master (
    output in_valid, in_result, in_op, in_rd, in_setflags, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_setflags, out_nzcv
  );

  modport slave (
    input  in_valid, in_result, in_op, in_rd, in_setflags, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_setflags, out_nzcv
  );

endinterface

// File: rtl/fp_writeback_stage_classify.sv
// ---------------------------------------------------------------------------
// fp_classify
// Combinational IEEE-754 single classifier.
//   data : FP word (sign, 8-bit exponent, 23-bit mantissa)
//   cls  : zero / denorm / normal / inf / NaN
// ---------------------------------------------------------------------------
module fp_classify
  import fp_pkg::*;
(
  input  logic [EXP_W+MAN_W:0] data,
  output fp_class_e            cls
);

  logic [EXP_W-1:0] expo;
  logic [MAN_W-1:0] man;

  assign expo = data[EXP_W+MAN_W-1:MAN_W];
  assign man  = data[MAN_W-1:0];

  always_comb begin
    cls = FPC_NORMAL;
    if (expo == '0) begin
      cls = (man == '0) ? FPC_ZERO : FPC_DENORM;
    end else if (expo == '1) begin
      cls = (man == '0) ? FPC_INF : FPC_NAN;
    end
  end

endmodule

// File: rtl/fp_writeback_stage.sv
// ---------------------------------------------------------------------------
// fp_writeback_stage
// Registered stage behind the FP add/mul unit. Each accepted result is
// classified, tagged with NZCV flags and buffered in a DEPTH-entry FIFO that
// feeds register-file writeback. Exception flags accumulate in a sticky
// register until fpscr_clr.
//   clk, rst_n    : clock (rising edge), async active-low reset
//   bus           : slave side of the in/out valid-ready handshakes
//   fpscr_clr     : clear sticky flags (a same-cycle push still ORs in)
//   sticky_flags  : {IOC,OFC,UFC,ZRC}
// ---------------------------------------------------------------------------
module fp_writeback_stage
  import fp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_writeback_stage_if.slave  bus,
  input  logic                 fpscr_clr,
  output logic [3:0]           sticky_flags
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [RD_W-1:0]   rd_mem   [DEPTH];
  logic              sf_mem   [DEPTH];
  logic [3:0]        nzcv_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  fp_class_e         push_cls;
  logic [3:0]        push_nzcv;
  logic [3:0]        push_flags;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  // A pop never frees space for a same-cycle push: in_ready depends only on
  // count, keeping out_ready off the in_ready path.
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && bus.out_ready;

  // Invalid opcodes write an all-ones NaN pattern instead of the result.
  always_comb begin
    push_data = {DATA_W{1'b1}};
    case (bus.in_op)
      FP_OP_ADD, FP_OP_MUL: push_data = bus.in_result;
      default:              push_data = {DATA_W{1'b1}};
    endcase
  end

  fp_classify u_classify (
    .data (push_data),
    .cls  (push_cls)
  );

  // N is suppressed for NaN so a negative-signed NaN does not read as "less than".
  always_comb begin
    push_nzcv         = '0;
    push_nzcv[NZCV_N] = push_data[DATA_W-1] & (push_cls != FPC_NAN);
    push_nzcv[NZCV_Z] = (push_cls == FPC_ZERO);
    push_nzcv[NZCV_C] = 1'b0;
    push_nzcv[NZCV_V] = (push_cls == FPC_NAN);
  end

  assign push_flags = sticky_bits(push_cls, bus.in_op[1]);

  // Storage is reset so the head outputs read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        rd_mem[i]   <= '0;
        sf_mem[i]   <= 1'b0;
        nzcv_mem[i] <= '0;
      end
    end else if (push) begin
      data_mem[wr_ptr] <= push_data;
      rd_mem[wr_ptr]   <= bus.in_rd;
      sf_mem[wr_ptr]   <= bus.in_setflags;
      nzcv_mem[wr_ptr] <= push_nzcv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Clear takes effect before the pushed entry's bits are merged in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
    end else if (fpscr_clr) begin
      sticky_flags <= push ? push_flags : 4'b0000;
    end else if (push) begin
      sticky_flags <= sticky_flags | push_flags;
    end
  end

  assign bus.in_ready     = !full;
  assign bus.out_valid    = !empty;
  assign bus.out_data     = data_mem[rd_ptr];
  assign bus.out_rd       = rd_mem[rd_ptr];
  assign bus.out_setflags = sf_mem[rd_ptr];
  assign bus.out_nzcv     = nzcv_mem[rd_ptr];

endmodule

// File: tb/tb_fp_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_fp_writeback_stage
// Self-checking bench for fp_writeback_stage: directed scenarios with
// hand-computed expectations, then randomized traffic compared every cycle
// against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_fp_writeback_stage;

  localparam int DATA_W = 32;
  localparam int RD_W   = 4;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  rd;
    logic        sf;
    logic [3:0]  nzcv;
  } entry_t;

  logic       clk;
  logic       rst_n;
  logic       fpscr_clr;
  logic [3:0] sticky_flags;

  fp_writeback_stage_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();

  fp_writeback_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .fpscr_clr    (fpscr_clr),
    .sticky_flags (sticky_flags)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 0;

  entry_t     modelQ[$];
  logic [3:0] modelSticky = 4'b0000;

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference behaviour expressed directly on the IEEE-754 fields.
  function automatic logic isNan(logic [31:0] d);
    return (d[30:23] == 8'hFF) && (d[22:0] != 23'd0);
  endfunction
  function automatic logic isInf(logic [31:0] d);
    return (d[30:23] == 8'hFF) && (d[22:0] == 23'd0);
  endfunction
  function automatic logic isZero(logic [31:0] d);
    return d[30:0] == 31'd0;
  endfunction
  function automatic logic isDenorm(logic [31:0] d);
    return (d[30:23] == 8'h00) && (d[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] modelData(logic [31:0] r, logic [1:0] op);
    return op[1] ? 32'hFFFF_FFFF : r;
  endfunction
  function automatic logic [3:0] modelNzcv(logic [31:0] d);
    return {d[31] & !isNan(d), isZero(d), 1'b0, isNan(d)};
  endfunction
  function automatic logic [3:0] modelFlags(logic [31:0] d, logic [1:0] op);
    return {isNan(d) | op[1], isInf(d), isDenorm(d), isZero(d)};
  endfunction

  // Reference model: reacts to each clock edge and to the async reset.
  initial begin
    bit         doPush;
    bit         doPop;
    entry_t     e;
    logic [3:0] nb;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        modelQ.delete();
        modelSticky = 4'b0000;
      end else begin
        doPush = bus.in_valid && (modelQ.size() < DEPTH);
        doPop  = (modelQ.size() > 0) && bus.out_ready;
        e.data = modelData(bus.in_result, bus.in_op);
        e.rd   = bus.in_rd;
        e.sf   = bus.in_setflags;
        e.nzcv = modelNzcv(e.data);
        nb     = doPush ? modelFlags(e.data, bus.in_op) : 4'b0000;
        if (doPop)  void'(modelQ.pop_front());
        if (doPush) modelQ.push_back(e);
        modelSticky = fpscr_clr ? nb : (modelSticky | nb);
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("out_valid", bus.out_valid, modelQ.size() != 0);
    cmp("in_ready", bus.in_ready, modelQ.size() < DEPTH);
    cmp("sticky", sticky_flags, modelSticky);
    if (modelQ.size() != 0) begin
      cmp("out_data", bus.out_data, modelQ[0].data);
      cmp("out_rd", bus.out_rd, modelQ[0].rd);
      cmp("out_setflags", bus.out_setflags, modelQ[0].sf);
      cmp("out_nzcv", bus.out_nzcv, modelQ[0].nzcv);
    end
  endtask

  // Per-cycle compare, on the falling edge away from the sampling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) checkOutput();
    end
  end

  // Drive one cycle of inputs from a falling edge; returns at the next one.
  task automatic applyStimulus(input logic v, input logic [31:0] r, input logic [1:0] op,
                               input logic [3:0] rd, input logic sf, input logic ordy,
                               input logic clr);
    bus.in_valid    = v;
    bus.in_result   = r;
    bus.in_op       = op;
    bus.in_rd       = rd;
    bus.in_setflags = sf;
    bus.out_ready   = ordy;
    fpscr_clr       = clr;
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy, input int n);
    repeat (n) applyStimulus(1'b0, 32'd0, 2'b00, 4'd0, 1'b0, ordy, 1'b0);
  endtask

  function automatic logic [31:0] pickData();
    logic [31:0] d;
    case ($urandom_range(0, 7))
      0:       d = {1'($urandom), 31'd0};
      1:       d = {1'($urandom), 8'h00, 23'($urandom_range(1, 32'h7F_FFFF))};
      2:       d = {1'($urandom), 8'hFF, 23'd0};
      3:       d = {1'($urandom), 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
      default: d = $urandom;
    endcase
    return d;
  endfunction

  initial begin
    logic [1:0] op;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_result   = '0;
    bus.in_op       = 2'b00;
    bus.in_rd       = '0;
    bus.in_setflags = 1'b0;
    bus.out_ready   = 1'b0;
    fpscr_clr       = 1'b0;

    // Reset state
    #12;
    cmp("rst_out_valid", bus.out_valid, 1'b0);
    cmp("rst_in_ready", bus.in_ready, 1'b1);
    cmp("rst_sticky", sticky_flags, 4'b0000);
    cmp("rst_out_data", bus.out_data, 32'd0);
    cmp("rst_out_nzcv", bus.out_nzcv, 4'b0000);
    cmp("rst_out_rd", bus.out_rd, 4'd0);
    cmp("rst_out_setflags", bus.out_setflags, 1'b0);
    @(negedge clk);
    rst_n   = 1'b1;
    checkEn = 1'b1;
    idle(1'b1, 5);
    cmp("idle_out_valid", bus.out_valid, 1'b0);
    cmp("idle_sticky", sticky_flags, 4'b0000);

    // Single normal push
    applyStimulus(1'b1, 32'h3FC0_0000, 2'b00, 4'd3, 1'b0, 1'b1, 1'b0);
    cmp("t2_out_valid", bus.out_valid, 1'b1);
    cmp("t2_out_data", bus.out_data, 32'h3FC0_0000);
    cmp("t2_out_rd", bus.out_rd, 4'd3);
    cmp("t2_out_nzcv", bus.out_nzcv, 4'b0000);
    cmp("t2_sticky", sticky_flags, 4'b0000);

    // Special values, each popped the cycle after it lands
    applyStimulus(1'b1, 32'h7F80_0000, 2'b00, 4'd5, 1'b1, 1'b1, 1'b0);
    cmp("t3_inf_data", bus.out_data, 32'h7F80_0000);
    cmp("t3_inf_nzcv", bus.out_nzcv, 4'b0000);
    cmp("t3_inf_sticky", sticky_flags, 4'b0100);
    applyStimulus(1'b1, 32'h7FC0_0000, 2'b01, 4'd6, 1'b1, 1'b1, 1'b0);
    cmp("t3_nan_nzcv", bus.out_nzcv, 4'b0001);
    cmp("t3_nan_sticky", sticky_flags, 4'b1100);
    applyStimulus(1'b1, 32'h8000_0000, 2'b00, 4'd7, 1'b0, 1'b1, 1'b0);
    cmp("t3_negzero_nzcv", bus.out_nzcv, 4'b1100);
    cmp("t3_negzero_sticky", sticky_flags, 4'b1101);
    applyStimulus(1'b1, 32'h0000_0001, 2'b01, 4'd8, 1'b0, 1'b1, 1'b0);
    cmp("t3_denorm_nzcv", bus.out_nzcv, 4'b0000);
    cmp("t3_final_sticky", sticky_flags, 4'b1111);
    idle(1'b1, 1);
    cmp("t3_drained", bus.out_valid, 1'b0);

    // Backpressure: A and B fill the buffer, C waits
    applyStimulus(1'b1, 32'h4049_0FDB, 2'b00, 4'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hC000_0000, 2'b01, 4'd2, 1'b1, 1'b0, 1'b0);
    cmp("t4_full_in_ready", bus.in_ready, 1'b0);
    cmp("t4_head_a", bus.out_data, 32'h4049_0FDB);
    applyStimulus(1'b1, 32'h3F80_0000, 2'b00, 4'd4, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h3F80_0000, 2'b00, 4'd4, 1'b0, 1'b0, 1'b0);
    cmp("t4_held_head_a", bus.out_data, 32'h4049_0FDB);
    cmp("t4_held_in_ready", bus.in_ready, 1'b0);
    applyStimulus(1'b1, 32'h3F80_0000, 2'b00, 4'd4, 1'b0, 1'b1, 1'b0);
    cmp("t4_head_b", bus.out_data, 32'hC000_0000);
    cmp("t4_head_b_nzcv", bus.out_nzcv, 4'b1000);
    applyStimulus(1'b1, 32'h3F80_0000, 2'b00, 4'd4, 1'b0, 1'b1, 1'b0);
    cmp("t4_head_c", bus.out_data, 32'h3F80_0000);
    cmp("t4_head_c_rd", bus.out_rd, 4'd4);
    idle(1'b1, 1);
    cmp("t4_drained", bus.out_valid, 1'b0);

    // Invalid opcode together with a sticky clear
    applyStimulus(1'b1, 32'd0, 2'b10, 4'd9, 1'b1, 1'b1, 1'b1);
    cmp("t5_forced_data", bus.out_data, 32'hFFFF_FFFF);
    cmp("t5_nzcv", bus.out_nzcv, 4'b0001);
    cmp("t5_sticky", sticky_flags, 4'b1000);
    idle(1'b1, 1);

    // Mid-cycle reset with two entries buffered
    applyStimulus(1'b1, 32'h4120_0000, 2'b00, 4'd10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4130_0000, 2'b01, 4'd11, 1'b1, 1'b0, 1'b0);
    cmp("t6_pre_valid", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    cmp("t6_async_out_valid", bus.out_valid, 1'b0);
    cmp("t6_async_in_ready", bus.in_ready, 1'b1);
    cmp("t6_async_sticky", sticky_flags, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1, 3);
    cmp("t6_no_stale", bus.out_valid, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      op = ($urandom_range(0, 7) == 0) ? {1'b1, 1'($urandom)} : {1'b0, 1'($urandom)};
      applyStimulus($urandom_range(0, 3) != 0, pickData(), op, 4'($urandom),
                    1'($urandom), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 15) == 0);
    end
    idle(1'b1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
